// File: rtl/bitbrick_shift_acc_if.sv
// Stream bundle for bitbrick_shift_acc: bitbrick beats in, finished dot-products out.
// The slave side is the accumulator; the master side is whoever feeds and drains it.
interface bitbrick_shift_acc_if #(
    parameter int NUM_BRICKS  = 16,
    parameter int P_WIDTH     = 6,
    parameter int SHIFT_WIDTH = 4,
    parameter int ACC_WIDTH   = 32
);
    logic                              in_valid;
    logic                              in_ready;
    logic                              in_last;
    logic [NUM_BRICKS*P_WIDTH-1:0]     products;
    logic [NUM_BRICKS*SHIFT_WIDTH-1:0] shifts;
    logic [NUM_BRICKS-1:0]             brick_en;
    logic                              out_valid;
    logic                              out_ready;
    logic [ACC_WIDTH-1:0]              out_acc;
    logic                              out_ovf;

    modport master (
        output in_valid, in_last, products, shifts, brick_en, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf
    );

    modport slave (
        input  in_valid, in_last, products, shifts, brick_en, out_ready,
        output in_ready, out_valid, out_acc, out_ovf
    );
endinterface

// File: rtl/bitbrick_shift_acc.sv
// Three-stage shift/sum/accumulate pipeline for a BitFusion fusion unit.
// One global advance enable freezes every stage while a finished sum waits downstream.
module bitbrick_shift_acc #(
    parameter int NUM_BRICKS  = 16,
    parameter int P_WIDTH     = 6,
    parameter int SHIFT_WIDTH = 4,
    parameter int ACC_WIDTH   = 32
) (
    input  logic                clk,
    input  logic                rst,
    bitbrick_shift_acc_if.slave bus
);
    localparam int LEVELS = $clog2(NUM_BRICKS);
    localparam int MSB    = ACC_WIDTH - 1;

    typedef enum logic {IDLE, RUN} state_t;

    logic                 w_adv;
    logic [ACC_WIDTH-1:0] w_ext  [NUM_BRICKS];
    logic [ACC_WIDTH-1:0] w_term [NUM_BRICKS];
    logic                 r_s1Valid;
    logic                 r_s1Last;
    logic [ACC_WIDTH-1:0] r_s1Term [NUM_BRICKS];
    logic [ACC_WIDTH-1:0] w_tree [LEVELS+1][NUM_BRICKS];
    logic                 r_s2Valid;
    logic                 r_s2Last;
    logic [ACC_WIDTH-1:0] r_s2Sum;
    state_t               r_state;
    state_t               w_stateNext;
    logic                 w_fire;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] w_accNext;
    logic [ACC_WIDTH-1:0] w_addSum;
    logic [ACC_WIDTH-1:0] w_result;
    logic                 r_ovf;
    logic                 w_ovfNext;
    logic                 w_addOvf;
    logic                 w_resultOvf;
    logic                 w_emit;
    logic                 r_outValid;
    logic [ACC_WIDTH-1:0] r_outAcc;
    logic                 r_outOvf;

    // in_ready follows out_ready combinationally so a stall costs no extra cycle
    assign w_adv         = !r_outValid || bus.out_ready;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_outValid;
    assign bus.out_acc   = r_outAcc;
    assign bus.out_ovf   = r_outOvf;

    always_comb begin
        for (int i = 0; i < NUM_BRICKS; i++) begin
            w_ext[i]  = {{(ACC_WIDTH-P_WIDTH){bus.products[i*P_WIDTH+P_WIDTH-1]}},
                         bus.products[i*P_WIDTH +: P_WIDTH]};
            w_term[i] = bus.brick_en[i]
                      ? (w_ext[i] << bus.shifts[i*SHIFT_WIDTH +: SHIFT_WIDTH])
                      : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s1Last  <= 1'b0;
            for (int i = 0; i < NUM_BRICKS; i++) r_s1Term[i] <= '0;
        end else if (w_adv) begin
            r_s1Valid <= bus.in_valid;
            r_s1Last  <= bus.in_last;
            for (int i = 0; i < NUM_BRICKS; i++) r_s1Term[i] <= w_term[i];
        end
    end

    // Pairwise reduction: level l+1 holds NUM_BRICKS>>(l+1) partial sums of level l
    always_comb begin
        for (int l = 0; l <= LEVELS; l++) begin
            for (int j = 0; j < NUM_BRICKS; j++) w_tree[l][j] = '0;
        end
        for (int j = 0; j < NUM_BRICKS; j++) w_tree[0][j] = r_s1Term[j];
        for (int l = 0; l < LEVELS; l++) begin
            for (int j = 0; j < (NUM_BRICKS >> (l+1)); j++) begin
                w_tree[l+1][j] = w_tree[l][2*j] + w_tree[l][2*j+1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2Valid <= 1'b0;
            r_s2Last  <= 1'b0;
            r_s2Sum   <= '0;
        end else if (w_adv) begin
            r_s2Valid <= r_s1Valid;
            r_s2Last  <= r_s1Last;
            r_s2Sum   <= w_tree[LEVELS][0];
        end
    end

    assign w_fire = r_s2Valid && w_adv;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (w_fire && !r_s2Last) w_stateNext = RUN;
            RUN:     if (w_fire && r_s2Last)  w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Overflow: both operands share a sign and the wrapped sum flips it
    always_comb begin
        w_addSum    = r_acc + r_s2Sum;
        w_addOvf    = (r_acc[MSB] == r_s2Sum[MSB]) && (w_addSum[MSB] != r_acc[MSB]);
        w_accNext   = r_acc;
        w_ovfNext   = r_ovf;
        w_emit      = 1'b0;
        w_result    = '0;
        w_resultOvf = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fire) begin
                    w_ovfNext = 1'b0;
                    if (r_s2Last) begin
                        w_emit    = 1'b1;
                        w_result  = r_s2Sum;
                        w_accNext = '0;
                    end else begin
                        w_accNext = r_s2Sum;
                    end
                end
            end
            RUN: begin
                if (w_fire) begin
                    if (r_s2Last) begin
                        w_emit      = 1'b1;
                        w_result    = w_addSum;
                        w_resultOvf = r_ovf | w_addOvf;
                        w_accNext   = '0;
                        w_ovfNext   = 1'b0;
                    end else begin
                        w_accNext = w_addSum;
                        w_ovfNext = r_ovf | w_addOvf;
                    end
                end
            end
            default: ;
        endcase
    end

    // A fresh result overwrites one being handed off in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_outValid <= 1'b0;
            r_outAcc   <= '0;
            r_outOvf   <= 1'b0;
        end else begin
            r_acc <= w_accNext;
            r_ovf <= w_ovfNext;
            if (w_emit) begin
                r_outValid <= 1'b1;
                r_outAcc   <= w_result;
                r_outOvf   <= w_resultOvf;
            end else if (bus.out_ready) begin
                r_outValid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bitbrick_shift_acc.sv
// Self-checking bench for bitbrick_shift_acc: directed scenarios plus randomized beats
// checked against an integer-arithmetic model of the dot-product accumulation.
module tb_bitbrick_shift_acc;
    localparam int NB  = 16;
    localparam int PW  = 6;
    localparam int SW  = 4;
    localparam int AW  = 32;
    localparam int SWB = 3;
    localparam int AWB = 24;
    localparam longint NONE = 64'h7FFF_0000_0000_0000;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    bitbrick_shift_acc_if #(.NUM_BRICKS(NB), .P_WIDTH(PW), .SHIFT_WIDTH(SW), .ACC_WIDTH(AW)) busA ();
    bitbrick_shift_acc_if #(.NUM_BRICKS(NB), .P_WIDTH(PW), .SHIFT_WIDTH(SWB), .ACC_WIDTH(AWB)) busB ();

    bitbrick_shift_acc #(.NUM_BRICKS(NB), .P_WIDTH(PW), .SHIFT_WIDTH(SW), .ACC_WIDTH(AW))
        dutA (.clk(clk), .rst(rst), .bus(busA));
    bitbrick_shift_acc #(.NUM_BRICKS(NB), .P_WIDTH(PW), .SHIFT_WIDTH(SWB), .ACC_WIDTH(AWB))
        dutB (.clk(clk), .rst(rst), .bus(busB));

    int     cycle = 0;
    int     lastAcceptCycle = 0;
    longint modelAcc = 0;
    bit     modelOvf = 1'b0;
    bit     modelRun = 1'b0;
    longint beatTotal;
    bit     beatOvf;
    longint expAcc[$];
    bit     expOvf[$];
    longint obsAcc[$];
    bit     obsOvf[$];
    int     obsCycle[$];
    longint obsAccB[$];
    bit     obsOvfB[$];

    function automatic longint wrapTo(input longint v, input int w);
        longint m;
        longint r;
        m = longint'(1) << w;
        r = v % m;
        if (r < 0) r += m;
        if (r >= (m >> 1)) r -= m;
        return r;
    endfunction

    function automatic longint beatSumA(input logic [NB*PW-1:0] p, input logic [NB*SW-1:0] s,
                                        input logic [NB-1:0] en);
        longint total;
        total = 0;
        for (int i = 0; i < NB; i++) begin
            if (en[i]) total += longint'($signed(p[i*PW +: PW])) * (longint'(1) << s[i*SW +: SW]);
        end
        return total;
    endfunction

    function automatic longint pickA(input int i);
        return (i < obsAcc.size()) ? obsAcc[i] : NONE;
    endfunction

    function automatic longint pickB(input int i);
        return (i < obsAccB.size()) ? obsAccB[i] : NONE;
    endfunction

    // Model: a sum is a plain integer total; overflow means the true total left the signed range
    always @(negedge clk) begin
        cycle++;
        if (rst) begin
            modelAcc = 0;
            modelOvf = 1'b0;
            modelRun = 1'b0;
            expAcc.delete();
            expOvf.delete();
        end else begin
            if (busA.out_valid && busA.out_ready) begin
                obsAcc.push_back(longint'($signed(busA.out_acc)));
                obsOvf.push_back(busA.out_ovf);
                obsCycle.push_back(cycle);
            end
            if (busB.out_valid && busB.out_ready) begin
                obsAccB.push_back(longint'($signed(busB.out_acc)));
                obsOvfB.push_back(busB.out_ovf);
            end
            if (busA.in_valid && busA.in_ready) begin
                lastAcceptCycle = cycle;
                beatTotal = beatSumA(busA.products, busA.shifts, busA.brick_en);
                beatOvf   = 1'b0;
                if (modelRun) begin
                    beatTotal = modelAcc + beatTotal;
                    beatOvf   = modelOvf || (beatTotal > ((longint'(1) << (AW-1)) - 1))
                                         || (beatTotal < -(longint'(1) << (AW-1)));
                end
                beatTotal = wrapTo(beatTotal, AW);
                if (busA.in_last) begin
                    expAcc.push_back(beatTotal);
                    expOvf.push_back(beatOvf);
                    modelAcc = 0;
                    modelOvf = 1'b0;
                    modelRun = 1'b0;
                end else begin
                    modelAcc = beatTotal;
                    modelOvf = beatOvf;
                    modelRun = 1'b1;
                end
            end
        end
    end

    task automatic idleInputs();
        busA.in_valid = 1'b0; busA.in_last = 1'b0; busA.products = '0; busA.shifts = '0; busA.brick_en = '0;
        busB.in_valid = 1'b0; busB.in_last = 1'b0; busB.products = '0; busB.shifts = '0; busB.brick_en = '0;
    endtask

    task automatic clearQueues();
        expAcc.delete(); expOvf.delete();
        obsAcc.delete(); obsOvf.delete(); obsCycle.delete();
        obsAccB.delete(); obsOvfB.delete();
    endtask

    task automatic driveBeatA(input logic [NB*PW-1:0] p, input logic [NB*SW-1:0] s,
                              input logic [NB-1:0] en, input logic last);
        int guard;
        guard = 0;
        busA.in_valid = 1'b1; busA.products = p; busA.shifts = s; busA.brick_en = en; busA.in_last = last;
        @(negedge clk);
        while (!busA.in_ready && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        busA.in_valid = 1'b0;
        busA.in_last  = 1'b0;
    endtask

    task automatic waitObsA(input int n);
        for (int k = 0; k < 60 && obsAcc.size() < n; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        busA.out_ready = 1'b0;
        busB.out_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (busA.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", busA.out_valid); end
        vectors++;
        if (busA.out_acc !== '0) begin miscompares++; $display("[TB] FAIL reset_out_acc: got %h expected 0", busA.out_acc); end
        vectors++;
        if (busA.out_ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_ovf: got %0b expected 0", busA.out_ovf); end
        vectors++;
        if (busA.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", busA.in_ready); end
        vectors++;
        if (busB.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid_b: got %0b expected 0", busB.out_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        busA.out_ready = 1'b1;
        busB.out_ready = 1'b1;
    endtask

    task automatic test_single_beat();
        logic [NB*PW-1:0] p;
        logic [NB*SW-1:0] s;
        int               acc0;
        clearQueues();
        p = {$urandom(), $urandom(), $urandom()};
        s = {$urandom(), $urandom()};
        p[0 +: PW] = 6'b111110; s[0 +: SW] = 4'd4;
        p[PW +: PW] = 6'd9;     s[SW +: SW] = 4'd0;
        driveBeatA(p, s, 16'h0003, 1'b1);
        acc0 = lastAcceptCycle;
        waitObsA(1);
        vectors++;
        if (obsAcc.size() !== 1) begin miscompares++; $display("[TB] FAIL single_count: got %0d expected 1", obsAcc.size()); end
        vectors++;
        if (pickA(0) !== longint'(-23)) begin miscompares++; $display("[TB] FAIL single_acc: got %0d expected -23", pickA(0)); end
        vectors++;
        if (obsOvf.size() > 0 && obsOvf[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL single_ovf: got 1 expected 0"); end
        vectors++;
        if (obsCycle.size() > 0 && obsCycle[0] - acc0 !== 3) begin
            miscompares++; $display("[TB] FAIL single_latency: got %0d expected 3", obsCycle[0] - acc0);
        end
    endtask

    task automatic test_three_beat();
        int acc3;
        clearQueues();
        for (int b = 0; b < 3; b++) driveBeatA({NB{6'd1}}, '0, '1, (b == 2));
        acc3 = lastAcceptCycle;
        waitObsA(1);
        vectors++;
        if (obsAcc.size() !== 1) begin miscompares++; $display("[TB] FAIL three_count: got %0d expected 1", obsAcc.size()); end
        vectors++;
        if (pickA(0) !== longint'(48)) begin miscompares++; $display("[TB] FAIL three_acc: got %0d expected 48", pickA(0)); end
        vectors++;
        if (obsCycle.size() > 0 && obsCycle[0] - acc3 !== 3) begin
            miscompares++; $display("[TB] FAIL three_latency: got %0d expected 3", obsCycle[0] - acc3);
        end
    endtask

    task automatic test_back_to_back();
        int guard;
        clearQueues();
        busA.out_ready = 1'b0;
        driveBeatA({NB{6'd1}}, '0, '1, 1'b1);
        driveBeatA({{(NB-1){6'd0}}, 6'd5}, '0, 16'h0001, 1'b1);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!busA.out_valid && guard < 20);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            vectors++;
            if (busA.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_in_ready[%0d]: got %0b expected 0", k, busA.in_ready); end
            vectors++;
            if (busA.out_valid !== 1'b1 || busA.out_acc !== 32'd16) begin
                miscompares++; $display("[TB] FAIL stall_hold[%0d]: got valid=%0b acc=%0d expected valid=1 acc=16", k, busA.out_valid, busA.out_acc);
            end
        end
        @(posedge clk); #1;
        busA.out_ready = 1'b1;
        waitObsA(2);
        vectors++;
        if (obsAcc.size() !== 2) begin miscompares++; $display("[TB] FAIL b2b_count: got %0d expected 2", obsAcc.size()); end
        vectors++;
        if (pickA(0) !== longint'(16)) begin miscompares++; $display("[TB] FAIL b2b_first: got %0d expected 16", pickA(0)); end
        vectors++;
        if (pickA(1) !== longint'(5)) begin miscompares++; $display("[TB] FAIL b2b_second: got %0d expected 5", pickA(1)); end
    endtask

    task automatic test_brick_en();
        clearQueues();
        driveBeatA({NB{6'b100000}}, {NB{4'd12}}, '0, 1'b1);
        waitObsA(1);
        vectors++;
        if (pickA(0) !== longint'(0)) begin miscompares++; $display("[TB] FAIL masked_acc: got %0d expected 0", pickA(0)); end
    endtask

    task automatic test_overflow();
        longint beat;
        longint total;
        longint expWrap;
        bit     expOv;
        int     beats;
        clearQueues();
        beats = 140;
        beat  = 0;
        for (int i = 0; i < NB; i++) beat += 31 * 128;
        total   = beat * beats;
        expWrap = wrapTo(total, AWB);
        expOv   = total > ((longint'(1) << (AWB-1)) - 1);
        busB.products = {NB{6'd31}};
        busB.shifts   = {NB{3'd7}};
        busB.brick_en = '1;
        for (int k = 0; k < beats; k++) begin
            busB.in_valid = 1'b1;
            busB.in_last  = (k == beats - 1);
            @(posedge clk); #1;
        end
        busB.products = {{(NB-1){6'd0}}, 6'd1};
        busB.shifts   = '0;
        busB.brick_en = 16'h0001;
        busB.in_last  = 1'b1;
        @(posedge clk); #1;
        busB.in_valid = 1'b0;
        busB.in_last  = 1'b0;
        for (int k = 0; k < 60 && obsAccB.size() < 2; k++) @(negedge clk);
        @(posedge clk); #1;
        vectors++;
        if (pickB(0) !== expWrap) begin miscompares++; $display("[TB] FAIL ovf_acc: got %0d expected %0d", pickB(0), expWrap); end
        vectors++;
        if (obsOvfB.size() < 1 || obsOvfB[0] !== expOv) begin miscompares++; $display("[TB] FAIL ovf_flag: got size=%0d expected flag %0b", obsOvfB.size(), expOv); end
        vectors++;
        if (pickB(1) !== longint'(1)) begin miscompares++; $display("[TB] FAIL ovf_next_acc: got %0d expected 1", pickB(1)); end
        vectors++;
        if (obsOvfB.size() < 2 || obsOvfB[1] !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_next_flag: got size=%0d expected flag 0", obsOvfB.size()); end
    endtask

    task automatic test_reset_mid_sum();
        clearQueues();
        for (int b = 0; b < 2; b++) driveBeatA({$urandom(), $urandom(), $urandom()}, {$urandom(), $urandom()}, '1, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (busA.out_valid !== 1'b0 || busA.out_acc !== '0 || busA.out_ovf !== 1'b0) begin
            miscompares++; $display("[TB] FAIL midreset_outputs: got valid=%0b acc=%h ovf=%0b expected all 0", busA.out_valid, busA.out_acc, busA.out_ovf);
        end
        @(posedge clk); #1;
        driveBeatA({{(NB-1){6'd0}}, 6'd7}, '0, 16'h0001, 1'b1);
        waitObsA(1);
        vectors++;
        if (obsAcc.size() !== 1) begin miscompares++; $display("[TB] FAIL midreset_count: got %0d expected 1", obsAcc.size()); end
        vectors++;
        if (pickA(0) !== longint'(7)) begin miscompares++; $display("[TB] FAIL midreset_acc: got %0d expected 7", pickA(0)); end
    endtask

    task automatic test_random();
        int numBeats;
        int sent;
        bit haveBeat;
        bit accepted;
        clearQueues();
        numBeats = 80;
        sent     = 0;
        haveBeat = 1'b0;
        for (int cyc = 0; cyc < 3000 && sent < numBeats; cyc++) begin
            if (!haveBeat && $urandom_range(0, 4) != 0) begin
                busA.products = {$urandom(), $urandom(), $urandom()};
                busA.shifts   = {$urandom(), $urandom()};
                busA.brick_en = NB'($urandom());
                busA.in_last  = (sent == numBeats - 1) || ($urandom_range(0, 3) == 0);
                haveBeat = 1'b1;
            end
            busA.in_valid  = haveBeat;
            busA.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            accepted = busA.in_valid && busA.in_ready;
            @(posedge clk); #1;
            if (accepted) begin
                haveBeat = 1'b0;
                sent++;
            end
        end
        busA.in_valid  = 1'b0;
        busA.in_last   = 1'b0;
        busA.out_ready = 1'b1;
        waitObsA(expAcc.size());
        vectors++;
        if (obsAcc.size() !== expAcc.size() || sent !== numBeats) begin
            miscompares++; $display("[TB] FAIL random_count: got %0d results (%0d beats) expected %0d results (%0d beats)", obsAcc.size(), sent, expAcc.size(), numBeats);
        end
        for (int i = 0; i < expAcc.size(); i++) begin
            vectors++;
            if (pickA(i) !== expAcc[i] || (i < obsOvf.size() && obsOvf[i] !== expOvf[i])) begin
                miscompares++; $display("[TB] FAIL random_result[%0d]: got %0d expected %0d (ovf expected %0b)", i, pickA(i), expAcc[i], expOvf[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idleInputs();
        busA.out_ready = 1'b1;
        busB.out_ready = 1'b1;
        test_reset();
        test_single_beat();
        test_three_beat();
        test_back_to_back();
        test_brick_en();
        test_overflow();
        test_reset_mid_sum();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
